// File: rtl/piso_tx_if.sv
// Word-in / bit-out bundle for piso_tx. Handshake: a word moves on a rising
// edge where din_valid && din_ready; the source holds din stable until then.
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             busy;
  logic [1:0]       state_dbg;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, frame_start, busy, state_dbg
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, frame_start, busy, state_dbg
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with a one-word hold buffer; frames stream
// back to back. Define PISO_TX_PARITY_EN to append an even-parity bit per frame.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  piso_tx_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full, hold_full_d;
  logic             last, load, accept;
  logic             sout_d;
`ifdef PISO_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    shreg_d     = shreg;
    hold_d      = hold_q;
    hold_full_d = hold_full;
`ifdef PISO_TX_PARITY_EN
    parity_d    = parity_q;
    last        = (state == PARITY);
`else
    last        = (state == SHIFT) && (cnt == LAST_CNT);
`endif
    // accept needs an empty hold and load needs a full one, so they never coincide
    accept = bus.din_valid && !hold_full;
    load   = hold_full && ((state == IDLE) || last);

    if (accept) begin
      hold_d      = bus.din;
      hold_full_d = 1'b1;
    end

    case (state)
      SHIFT: begin
        if (cnt == LAST_CNT) begin
`ifdef PISO_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt + CW'(1);
          if (MSB_FIRST) shreg_d = shreg << 1;
          else           shreg_d = shreg >> 1;
        end
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: state_d = IDLE;
`endif
      default: ;
    endcase

    if (load) begin
      state_d     = SHIFT;
      cnt_d       = '0;
      shreg_d     = hold_q;
      hold_full_d = 1'b0;
`ifdef PISO_TX_PARITY_EN
      parity_d    = ^hold_q;
`endif
    end

    // outputs are registered from next-state values so they change only on edges
    sout_d = 1'b0;
    if (state_d == SHIFT) sout_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
`ifdef PISO_TX_PARITY_EN
    if (state_d == PARITY) sout_d = parity_d;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cnt             <= '0;
      shreg           <= '0;
      hold_q          <= '0;
      hold_full       <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      parity_q        <= 1'b0;
`endif
      bus.sout        <= 1'b0;
      bus.sout_valid  <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      shreg           <= shreg_d;
      hold_q          <= hold_d;
      hold_full       <= hold_full_d;
`ifdef PISO_TX_PARITY_EN
      parity_q        <= parity_d;
`endif
      bus.sout        <= sout_d;
      bus.sout_valid  <= (state_d != IDLE);
      bus.frame_start <= (state_d == SHIFT) && (cnt_d == '0);
      bus.busy        <= (state_d != IDLE) || hold_full_d;
    end
  end

  assign bus.din_ready = !hold_full;
  assign bus.state_dbg = state;

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in/serial-out transmitter that sits directly upstream of the 4-bit SIPO shift register and drives its serial `d` input. It accepts parallel words through a valid/ready handshake, buffers one word, and serializes each word one bit per clock with framing strobes. Consecutive words stream with no idle gap, so a downstream SIPO sees a continuous bit stream.

## Interface
- `WIDTH`, 4: data word width in bits (≥2).
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 goes out first; 0 = bit 0 first.

- `clk`  input  1  clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low reset. Low clears all state immediately, independent of `clk`.
- `din`  input  WIDTH  parallel word to transmit.
- `din_valid`  input  1  `din` is valid this cycle.
- `din_ready`  output  1  block can accept a word this cycle.
- `sout`  output  1  serial data; connects to the SIPO `d`.
- `sout_valid`  output  1  `sout` carries a live bit this cycle.
- `frame_start`  output  1  high during the first bit of each word.
- `busy`  output  1  shifter active or hold buffer occupied.

## Operation
- Reset values: `sout`=0, `sout_valid`=0, `frame_start`=0, `busy`=0, `din_ready`=1. Hold buffer empty, state IDLE, bit counter 0.
- Hold buffer (one word):
  - `din_ready` = !hold_full.
  - A word is accepted on an edge where `din_valid && din_ready`; `din` is written into the hold buffer.
  - The hold buffer empties on the edge that transfers it into the shifter.
- Shifter load: on any edge where hold_full and (state==IDLE, or the current cycle is the frame's final cycle), the shifter loads from the hold buffer. The counter resets to 0 and the state becomes SHIFT.
- States:
  - IDLE: `sout`=0, `sout_valid`=0.
  - SHIFT: `sout` = current bit in MSB_FIRST order; `sout_valid`=1; `frame_start`=1 when counter==0. The counter increments each edge. When counter==WIDTH-1, the next state is PARITY if the parity feature is compiled in; otherwise it is SHIFT (reload) if hold_full, else IDLE.
  - PARITY: present only with the parity macro. One cycle; `sout` = parity bit, `sout_valid`=1. The next state is SHIFT (reload) if hold_full, else IDLE.
- All outputs are registered, except `din_ready`, which is registered through hold_full.
- `busy` = (state!=IDLE) || hold_full.
- Boundary conditions:
  - `din_valid` while hold_full: the word is ignored and the source must hold it. No data is lost or duplicated.
  - A word accepted on the same edge as the final bit: it lands in hold and loads on the next edge. That produces a single gap cycle only if the hold buffer was empty at the final bit.
  - `din` changing while `din_valid`=0: no effect.
  - `reset` asserted mid-frame: the frame is aborted, outputs return to reset values asynchronously, and the partial word is discarded.

## Timing
- Latency from idle: word accepted at edge k → first bit on `sout` from edge k+1, with `frame_start` high for cycle k+1 only.
- Frame length: WIDTH cycles, or WIDTH+1 with parity.
- Throughput: a new word can be accepted the cycle after hold drains. Streaming stays gap-free as long as the source refills hold before the final bit of the current frame.
- `sout` changes only on rising `clk` edges (except reset), so the downstream SIPO samples a stable bit on the following edge.

## Configuration
- `PISO_TX_PARITY_EN`:
  - Defined: each frame ends with one extra even-parity bit (XOR of the data bits) in state PARITY, and the frame is WIDTH+1 cycles. `frame_start` and `sout_valid` follow the rules above.
  - Undefined: the PARITY state and parity logic are removed, and frames are exactly WIDTH cycles.

## Test plan
- Reset, then a single word with WIDTH=4, MSB_FIRST=1, `din`=4'b1001 → `sout` = 1,0,0,1 on four consecutive cycles. `sout_valid` is high for exactly 4 cycles, `frame_start` high on the first, and `busy` returns to 0 afterwards.
- Back-to-back 4'b1001 then 4'b0110, second word presented while the first shifts → 8 contiguous `sout_valid` cycles with stream 1,0,0,1,0,1,1,0 and `frame_start` on cycles 1 and 5.
- Backpressure: hold `din_valid`=1 with three words while the first is shifting → `din_ready` drops to 0 while hold is full. All three words are serialized in order, each exactly once.
- MSB_FIRST=0 with `din`=4'b0011 → `sout` = 1,1,0,0.
- Reset mid-frame: assert `reset` low after 2 bits of 4'b1111 → `sout` and `sout_valid` are 0 immediately, `din_ready`=1. After release, the new word 4'b0101 transmits cleanly.
- With `PISO_TX_PARITY_EN`: `din`=4'b1011 → `sout` = 1,0,1,1,1 (parity bit 1) over 5 valid cycles. `din`=4'b1001 → parity bit 0.
